// File: rtl/overlay_frame_buffer.sv
// Paletted overlay frame buffer: stores a low-resolution index image, upscales it,
// looks indices up in a writable palette and composites over the incoming VGA stream.
module overlay_frame_buffer #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int X_START     = 144,
    parameter int Y_START     = 35,
    parameter int SCALE_SHIFT = 2,
    parameter int PIX_BITS    = 2,
    parameter int ADDR_W      = 15
) (
    input  logic                VGA_CLK,
    input  logic                RESET,
    input  logic [12:0]         H_CNT,
    input  logic [12:0]         V_CNT,
    input  logic [7:0]          VGA_R_IN,
    input  logic [7:0]          VGA_G_IN,
    input  logic [7:0]          VGA_B_IN,
    input  logic                WR_EN,
    input  logic [ADDR_W-1:0]   WR_ADDR,
    input  logic [PIX_BITS-1:0] WR_DATA,
    input  logic                PAL_WE,
    input  logic [PIX_BITS-1:0] PAL_ADDR,
    input  logic [23:0]         PAL_DATA,
    input  logic                CLEAR,
    output logic                BUSY,
    output logic [7:0]          VGA_R_OUT,
    output logic [7:0]          VGA_G_OUT,
    output logic [7:0]          VGA_B_OUT
);

    localparam int FB_W  = H_RES >> SCALE_SHIFT;
    localparam int FB_H  = V_RES >> SCALE_SHIFT;
    localparam int DEPTH = FB_W * FB_H;
    localparam int PAL_N = 1 << PIX_BITS;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FB_W_A    = ADDR_W'(FB_W);
    localparam logic [12:0]       X_LO      = 13'(X_START);
    localparam logic [12:0]       X_HI      = 13'(X_START + H_RES);
    localparam logic [12:0]       Y_LO      = 13'(Y_START);
    localparam logic [12:0]       Y_HI      = 13'(Y_START + V_RES);

    typedef enum logic {IDLE, SWEEP} clr_state_t;

    clr_state_t                   state, state_nxt;
    logic [ADDR_W-1:0]            clr_addr, clr_addr_nxt;
    logic                         clr_we, busy, wr_ok;

    logic [PIX_BITS-1:0]          mem [DEPTH];
    logic [PAL_N-1:0][23:0]       pal;

    logic                         in_win;
    logic                         act_p0;
    logic [12:0]                  x_p0, y_p0;
    logic [23:0]                  rgb_p0;
    logic [ADDR_W-1:0]            addr_s2;
    logic                         vld_p1, act_p1;
    logic [ADDR_W-1:0]            addr_p1;
    logic [23:0]                  rgb_p1;
    logic                         vld_p2, act_p2;
    logic [PIX_BITS-1:0]          idx_p2;
    logic [23:0]                  rgb_p2;
    logic [23:0]                  rgb_out;

    function automatic logic [23:0] compose(input logic act, input logic [PIX_BITS-1:0] idx,
                                            input logic [23:0] bg, input logic [23:0] fg);
        return (act && idx != '0) ? fg : bg;
    endfunction

    // Clear engine: reset lands in SWEEP at address 0, so the RAM is always swept after reset
    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            state    <= SWEEP;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        clr_we       = 1'b0;
        case (state)
            IDLE: begin
                if (CLEAR) begin
                    state_nxt    = SWEEP;
                    clr_addr_nxt = '0;
                end
            end
            SWEEP: begin
                if (CLEAR) begin
                    clr_addr_nxt = '0;
                end else begin
                    clr_we       = !RESET;
                    clr_addr_nxt = clr_addr + 1'b1;
                    if (clr_addr == LAST_ADDR) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state == SWEEP);
    assign BUSY  = busy;
    assign wr_ok = WR_EN && !busy && !RESET && (WR_ADDR <= LAST_ADDR);

    // Single-port-write RAM; the read samples the old contents on a same-address collision
    always_ff @(posedge VGA_CLK) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        else if (wr_ok)
            mem[WR_ADDR] <= WR_DATA;
        idx_p2 <= mem[addr_p1];
    end

    always_ff @(posedge VGA_CLK) begin
        if (RESET)
            pal <= '0;
        else if (PAL_WE)
            pal[PAL_ADDR] <= PAL_DATA;
    end

    // Stage 1: window test and offset from the first active pixel
    assign in_win = (H_CNT >= X_LO) && (H_CNT < X_HI) && (V_CNT >= Y_LO) && (V_CNT < Y_HI);

    always_ff @(posedge VGA_CLK) begin
        if (RESET) act_p0 <= 1'b0;
        else       act_p0 <= in_win;
    end

    always_ff @(posedge VGA_CLK) begin
        x_p0   <= H_CNT - X_LO;
        y_p0   <= V_CNT - Y_LO;
        rgb_p0 <= {VGA_R_IN, VGA_G_IN, VGA_B_IN};
    end

    // Stage 2: row-major address; inactive pixels read address 0 and are ignored later
    assign addr_s2 = ADDR_W'(y_p0 >> SCALE_SHIFT) * FB_W_A + ADDR_W'(x_p0 >> SCALE_SHIFT);

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            vld_p1 <= 1'b0;
            act_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            act_p2 <= 1'b0;
        end else begin
            vld_p1 <= 1'b1;
            act_p1 <= act_p0;
            vld_p2 <= vld_p1;
            act_p2 <= act_p1;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        addr_p1 <= act_p0 ? addr_s2 : '0;
        rgb_p1  <= rgb_p0;
        rgb_p2  <= rgb_p1;
    end

    // Stage 3: palette lookup and composite; flushed slots drive black
    always_ff @(posedge VGA_CLK) begin
        if (RESET || !vld_p2)
            rgb_out <= '0;
        else
            rgb_out <= compose(act_p2, idx_p2, rgb_p2, pal[idx_p2]);
    end

    assign VGA_R_OUT = rgb_out[23:16];
    assign VGA_G_OUT = rgb_out[15:8];
    assign VGA_B_OUT = rgb_out[7:0];

endmodule

// File: tb/tb_overlay_frame_buffer.sv
// Randomized bench for overlay_frame_buffer against a cycle-level behavioural model
// of the frame store, palette, clear sweep and 3-cycle composite latency.
module tb_overlay_frame_buffer;

    localparam int DEPTH = 19200;

    logic        clk;
    logic        rst;
    logic [12:0] h_cnt, v_cnt;
    logic [23:0] rgb_in;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [1:0]  wr_data;
    logic        pal_we;
    logic [1:0]  pal_addr;
    logic [23:0] pal_data;
    logic        clear;
    logic        busy;
    logic [7:0]  r_out, g_out, b_out;

    overlay_frame_buffer dut (
        .VGA_CLK   (clk),
        .RESET     (rst),
        .H_CNT     (h_cnt),
        .V_CNT     (v_cnt),
        .VGA_R_IN  (rgb_in[23:16]),
        .VGA_G_IN  (rgb_in[15:8]),
        .VGA_B_IN  (rgb_in[7:0]),
        .WR_EN     (wr_en),
        .WR_ADDR   (wr_addr),
        .WR_DATA   (wr_data),
        .PAL_WE    (pal_we),
        .PAL_ADDR  (pal_addr),
        .PAL_DATA  (pal_data),
        .CLEAR     (clear),
        .BUSY      (busy),
        .VGA_R_OUT (r_out),
        .VGA_G_OUT (g_out),
        .VGA_B_OUT (b_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit act;
        int addr;
        int rgb;
        int idx;
    } smp_t;

    int   n_chk = 0;
    int   n_err = 0;
    int   m_mem [DEPTH];
    int   m_pal [4];
    int   m_clr_next = 0;
    int   m_clr_left = 0;
    int   m_rst_age  = 0;
    int   exp_rgb    = 0;
    bit   exp_busy   = 1'b0;
    smp_t q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_win(input int h, input int v);
        return (h >= 144) && (h < 784) && (v >= 35) && (v < 515);
    endfunction

    function automatic int fb_addr(input int h, input int v);
        return ((v - 35) / 4) * 160 + (h - 144) / 4;
    endfunction

    // Advances the reference by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit   busy_pre;
        smp_t s;
        smp_t f;
        busy_pre = (m_clr_left > 0);
        if (rst) m_rst_age = 0;
        else if (m_rst_age < 100) m_rst_age++;

        exp_rgb = 0;
        if (q.size() >= 3) begin
            s = q.pop_front();
            if (m_rst_age > 2)
                exp_rgb = (s.act && s.idx != 0) ? m_pal[s.idx] : s.rgb;
        end
        if (q.size() == 2) begin
            f = q[0];
            f.idx = f.act ? m_mem[f.addr] : 0;
            q[0] = f;
        end

        if (rst) begin
            for (int i = 0; i < 4; i++) m_pal[i] = 0;
        end else if (pal_we) begin
            m_pal[pal_addr] = int'(pal_data);
        end

        if (rst || clear) begin
            m_clr_next = 0;
            m_clr_left = DEPTH;
        end else if (m_clr_left > 0) begin
            m_mem[m_clr_next] = 0;
            m_clr_next++;
            m_clr_left--;
        end
        if (!rst && wr_en && !busy_pre && int'(wr_addr) < DEPTH)
            m_mem[wr_addr] = int'(wr_data);
        exp_busy = (m_clr_left > 0);

        s.act  = !rst && in_win(int'(h_cnt), int'(v_cnt));
        s.addr = s.act ? fb_addr(int'(h_cnt), int'(v_cnt)) : 0;
        s.rgb  = int'(rgb_in);
        s.idx  = 0;
        q.push_back(s);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("busy", 32'(busy), 32'(exp_busy));
        check_val("rgb", {8'h00, r_out, g_out, b_out}, 32'(exp_rgb));
    endtask

    task automatic blank_video();
        case ($urandom_range(0, 2))
            0: begin
                h_cnt = 13'($urandom_range(0, 143));
                v_cnt = 13'($urandom);
            end
            1: begin
                h_cnt = 13'($urandom_range(784, 8191));
                v_cnt = 13'($urandom);
            end
            default: begin
                h_cnt = 13'($urandom_range(144, 783));
                v_cnt = $urandom_range(0, 1) ? 13'($urandom_range(0, 34)) : 13'($urandom_range(515, 8191));
            end
        endcase
        rgb_in = 24'($urandom);
    endtask

    task automatic any_video();
        case ($urandom_range(0, 3))
            0, 1: begin
                h_cnt  = 13'($urandom_range(140, 260));
                v_cnt  = 13'($urandom_range(32, 50));
                rgb_in = 24'($urandom);
            end
            2: begin
                h_cnt  = 13'($urandom_range(760, 790));
                v_cnt  = 13'($urandom_range(505, 520));
                rgb_in = 24'($urandom);
            end
            default: blank_video();
        endcase
    endtask

    // Holds one pixel position for 4 edges; col < 0 expects the background to pass through.
    task automatic probe(input string tag, input int h, input int v, input logic [23:0] bg, input int col);
        logic [31:0] e;
        h_cnt  = 13'(h);
        v_cnt  = 13'(v);
        rgb_in = bg;
        repeat (4) step();
        if (col < 0) e = {8'h00, bg};
        else         e = 32'(col);
        check_val(tag, {8'h00, r_out, g_out, b_out}, e);
    endtask

    initial begin
        int          n;
        logic [23:0] x1;

        rst = 1'b1; clear = 1'b0;
        h_cnt = '0; v_cnt = '0; rgb_in = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        pal_we = 1'b0; pal_addr = '0; pal_data = '0;

        repeat (3) step();
        check_val("rst_busy", 32'(busy), 32'd1);
        check_val("rst_out", {8'h00, r_out, g_out, b_out}, 32'd0);
        rst = 1'b0;

        // run the sweep to address 1000, then reset in the middle of it
        repeat (1000) begin
            blank_video();
            step();
        end
        rst = 1'b1;
        blank_video();
        step();
        check_val("midrst_out", {8'h00, r_out, g_out, b_out}, 32'd0);
        rst = 1'b0;
        n = 0;
        while (busy && n < 25000) begin
            n++;
            if (n <= 3) check_val("flush_zero", {8'h00, r_out, g_out, b_out}, 32'd0);
            blank_video();
            step();
        end
        check_val("busy_len", 32'(n), 32'd19200);

        // idle: everything passes through
        rgb_in = 24'h123456;
        repeat (40) begin
            h_cnt = 13'($urandom_range(144, 783));
            v_cnt = 13'($urandom_range(35, 514));
            step();
        end
        probe("idle_pass", 400, 200, 24'h123456, -1);

        // first stored pixel covers a 4x4 block
        pal_we = 1'b1; pal_addr = 2'd1; pal_data = 24'hFF00FF;
        wr_en = 1'b1; wr_addr = 15'd0; wr_data = 2'd1;
        step();
        pal_we = 1'b0; wr_en = 1'b0;
        for (int v = 35; v <= 38; v++)
            for (int h = 144; h <= 147; h++)
                probe("blk0", h, v, 24'($urandom), 32'hFF00FF);
        probe("blk0_right", 148, 35, 24'($urandom), -1);
        probe("blk0_below", 144, 39, 24'($urandom), -1);

        // last stored pixel and out-of-range write
        pal_we = 1'b1; pal_addr = 2'd3; pal_data = 24'h00FF00;
        wr_en = 1'b1; wr_addr = 15'd19199; wr_data = 2'd3;
        step();
        pal_we = 1'b0;
        wr_addr = 15'd19200;
        step();
        wr_addr = 15'h7FFF;
        step();
        wr_en = 1'b0;
        probe("last_px", 783, 514, 24'($urandom), 32'h00FF00);
        probe("last_blk", 780, 511, 24'($urandom), 32'h00FF00);
        probe("past_h", 784, 514, 24'($urandom), -1);
        probe("past_v", 783, 515, 24'($urandom), -1);
        probe("no_alias", 144, 35, 24'($urandom), 32'hFF00FF);

        // write to address 5 on the edge where the pipeline reads it
        pal_we = 1'b1; pal_addr = 2'd2; pal_data = 24'h0000FF;
        blank_video();
        step();
        pal_we = 1'b0;
        x1 = 24'($urandom);
        h_cnt = 13'd164; v_cnt = 13'd35; rgb_in = x1;
        step();
        rgb_in = 24'($urandom);
        step();
        blank_video();
        wr_en = 1'b1; wr_addr = 15'd5; wr_data = 2'd2;
        step();
        wr_en = 1'b0;
        step();
        check_val("coll_old", {8'h00, r_out, g_out, b_out}, {8'h00, x1});
        step();
        check_val("coll_new", {8'h00, r_out, g_out, b_out}, 32'h0000FF);

        // fill the first rows with index 2, then sweep them away
        for (int a = 0; a < 256; a++) begin
            wr_en = 1'b1; wr_addr = 15'(a); wr_data = 2'd2;
            any_video();
            step();
        end
        wr_en = 1'b0;
        probe("filled", 144, 35, 24'($urandom), 32'h0000FF);

        clear = 1'b1;
        any_video();
        step();
        clear = 1'b0;
        repeat (100) begin
            any_video();
            wr_en = 1'($urandom_range(0, 1)); wr_addr = 15'($urandom_range(0, 300)); wr_data = 2'd2;
            step();
        end
        clear = 1'b1;
        wr_en = 1'b0;
        step();
        clear = 1'b0;
        n = 0;
        while (busy && n < 25000) begin
            n++;
            any_video();
            wr_en = 1'($urandom_range(0, 1)); wr_addr = 15'($urandom_range(0, 300)); wr_data = 2'd2;
            if (n == 5000) begin
                wr_en = 1'b1; wr_addr = 15'd0;
            end
            step();
        end
        wr_en = 1'b0;
        check_val("busy_len2", 32'(n), 32'd19200);
        probe("clr_a0", 144, 35, 24'($urandom), -1);
        probe("clr_a5", 164, 35, 24'($urandom), -1);
        probe("clr_last", 783, 514, 24'($urandom), -1);
        repeat (300) begin
            any_video();
            step();
        end

        // mixed random traffic
        repeat (3000) begin
            any_video();
            wr_en = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       wr_addr = 15'($urandom_range(19000, 19300));
                1:       wr_addr = 15'($urandom);
                default: wr_addr = 15'($urandom_range(0, 479));
            endcase
            wr_data  = 2'($urandom);
            pal_we   = ($urandom_range(0, 7) == 0);
            pal_addr = 2'($urandom);
            pal_data = 24'($urandom);
            step();
        end
        wr_en = 1'b0; pal_we = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/overlay_frame_buffer.md
Name: overlay_frame_buffer

Overview:
- Scaled, paletted overlay frame buffer between the VGA timing/pattern source and the VGA DAC outputs.
- Stores a low-resolution image of PIX_BITS-wide palette indices in on-chip RAM, written by the game logic.
- Upscales the image by 2^SCALE_SHIFT, looks each index up in a writable palette, and overlays the result on the incoming RGB stream. Index 0 is transparent.
- Includes a hardware clear engine.

Parameters:
- H_RES, 640, active width in VGA pixels.
- V_RES, 480, active height in VGA pixels.
- X_START, 144, H_CNT value of the first active pixel.
- Y_START, 35, V_CNT value of the first active line.
- SCALE_SHIFT, 2, log2 of the upscale factor; FB_W = H_RES>>SCALE_SHIFT, FB_H = V_RES>>SCALE_SHIFT.
- PIX_BITS, 2, bits per stored pixel (palette index width).
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= DEPTH = FB_W*FB_H (default 19200).

Ports:
- VGA_CLK  in  1  single clock for all logic.
- RESET  in  1  synchronous, active-high reset.
- H_CNT  in  13  horizontal counter from VGA timing.
- V_CNT  in  13  vertical counter from VGA timing.
- VGA_R_IN / VGA_G_IN / VGA_B_IN  in  8 each  background colour.
- WR_EN  in  1  pixel write strobe.
- WR_ADDR  in  ADDR_W  pixel address, row-major: y*FB_W + x.
- WR_DATA  in  PIX_BITS  palette index to store.
- PAL_WE  in  1  palette write strobe.
- PAL_ADDR  in  PIX_BITS  palette entry.
- PAL_DATA  in  24  {R,G,B} colour.
- CLEAR  in  1  start clear sweep (level sampled each cycle).
- BUSY  out  1  clear sweep in progress.
- VGA_R_OUT / VGA_G_OUT / VGA_B_OUT  out  8 each  composited colour, registered.

Behaviour:
- Reset:
  - RGB outputs 0 and all pipeline valid/active flags 0.
  - Palette entries all 0x000000.
  - The clear engine starts at address 0, so BUSY=1 from the cycle after RESET deasserts.
- Clear engine, states IDLE and SWEEP:
  - IDLE -> SWEEP when CLEAR=1 or on reset; clear address is set to 0.
  - In SWEEP, each cycle writes 0 to the clear address and increments it.
  - SWEEP -> IDLE after address DEPTH-1 is written. BUSY=1 for exactly DEPTH cycles.
  - CLEAR=1 during SWEEP restarts from address 0.
- Pixel writes:
  - Accepted when WR_EN=1, BUSY=0 and WR_ADDR < DEPTH. Otherwise silently dropped; no queuing.
  - The RAM write occurs at the clock edge that samples WR_EN.
- Palette writes:
  - Always accepted, including during SWEEP; take effect for lookups on the following cycle.
  - Writes to entry 0 are stored but never displayed.
- Read pipeline, fixed latency of 3 cycles: outputs at edge N+3 reflect H_CNT/V_CNT/RGB_IN sampled at edge N.
  - S1:
    - active = (X_START <= H_CNT < X_START+H_RES) and (Y_START <= V_CNT < Y_START+V_RES).
    - x = H_CNT-X_START, y = V_CNT-Y_START, computed in 13-bit unsigned arithmetic; values are only used when active.
    - RGB_IN is registered alongside.
  - S2: address = (y>>SCALE_SHIFT)*FB_W + (x>>SCALE_SHIFT), truncated to ADDR_W bits. Synchronous RAM read is issued.
  - S3: if active=0 or index=0, pass through the delayed RGB_IN; otherwise output palette[index].
- Read/write collision on the same address in the same cycle: the read returns the old data (read-before-write).
- RESET mid-sweep or mid-frame: the pipeline flushes, so outputs are 0 for the reset cycle and the following 2 cycles. The sweep restarts. RAM contents are otherwise unspecified until the sweep completes.
- Counter values beyond the active window (blanking) always yield pass-through, never a RAM alias.

Test Plan:
- Reset then idle: BUSY high exactly 19200 cycles, then 0. With RGB_IN=0x123456, any active pixel outputs 0x123456 three cycles later.
- Write WR_ADDR=0 data=1, palette[1]=0xFF00FF. At H_CNT=144..147 on V_CNT=35..38, output 0xFF00FF. At H_CNT=148, output RGB_IN.
- Write WR_ADDR=19199 data=3, palette[3]=0x00FF00. Pixel (H_CNT=783, V_CNT=514) outputs 0x00FF00. H_CNT=784 and V_CNT=515 output RGB_IN. WR_ADDR=19200 write is dropped with no alias at address 0.
- Assert CLEAR after filling RAM with 2s, and issue WR_EN during the sweep: writes are dropped, and after BUSY falls all pixels pass through.
- Same-cycle write of address 5 (0->2) while S2 reads address 5: that pixel shows pass-through; the next read of address 5 shows palette[2].
- RESET asserted mid-sweep at address 1000: outputs are 0 for 3 cycles, the sweep restarts, and BUSY stays high 19200 cycles from the release of reset.
